// File: rtl/axi3_wr_arbiter_if.sv
// AXI3 write-channel bundle (AW/W/B) for NP ports packed side by side; slot i of each
// field lives at [i*width +: width]. B id/resp are shared by all NP ports.
interface axi3_wr_arbiter_if #(
  parameter int unsigned NP = 1,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 4
);
  localparam int unsigned SW = DW / 8;

  logic [NP*IW-1:0] awid;
  logic [NP*AW-1:0] awaddr;
  logic [NP*4-1:0]  awlen;
  logic [NP*3-1:0]  awsize;
  logic [NP*2-1:0]  awburst;
  logic [NP-1:0]    awvalid;
  logic [NP-1:0]    awready;

  logic [NP*IW-1:0] wid;
  logic [NP*DW-1:0] wdata;
  logic [NP*SW-1:0] wstrb;
  logic [NP-1:0]    wlast;
  logic [NP-1:0]    wvalid;
  logic [NP-1:0]    wready;

  logic [IW-1:0]    bid;
  logic [1:0]       bresp;
  logic [NP-1:0]    bvalid;
  logic [NP-1:0]    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi3_wr_arbiter.sv
// Round-robin N:1 AXI3 write arbiter, one transaction outstanding, grant held AW->W->B.
// Optional WID/WLAST checking is enabled by defining AXI3_ARB_WID_CHECK_EN.
module axi3_wr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 4
) (
  input  logic             ACLK,
  input  logic             ARESET,
  axi3_wr_arbiter_if.slave  s,
  axi3_wr_arbiter_if.master m,
  output logic [N-1:0]     grant,
  output logic             wid_err
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   awid_q, awid_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [3:0]      awlen_q, awlen_d;
  logic [2:0]      awsize_q, awsize_d;
  logic [1:0]      awburst_q, awburst_d;

  logic [2*N-1:0]  req_dbl;
  logic [N-1:0]    req_rot;
  logic [PW-1:0]   offs;
  logic [PW:0]     pick_sum;
  logic [PW-1:0]   pick;
  logic            any_req;
  logic            w_hs;
  logic            b_hs;

  // Rotate requests so bit 0 is the pointer slot; lowest set bit is the winner.
  always_comb begin
    req_dbl  = {s.awvalid, s.awvalid} >> ptr_q;
    req_rot  = req_dbl[N-1:0];
    offs     = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req_rot[k]) offs = PW'(k);
    end
    any_req  = |req_rot;
    pick_sum = {1'b0, ptr_q} + {1'b0, offs};
    pick     = (pick_sum >= (PW+1)'(N)) ? PW'(pick_sum - (PW+1)'(N)) : pick_sum[PW-1:0];
  end

  always_comb begin
    w_hs = (state_q == StData) && s.wvalid[gidx_q] && m.wready[0];
    b_hs = (state_q == StResp) && m.bvalid[0] && s.bready[gidx_q];
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gidx_d    = pick;
          grant_d   = {{(N-1){1'b0}}, 1'b1} << pick;
          awid_d    = s.awid[pick*IW +: IW];
          awaddr_d  = s.awaddr[pick*AW +: AW];
          awlen_d   = s.awlen[pick*4 +: 4];
          awsize_d  = s.awsize[pick*3 +: 3];
          awburst_d = s.awburst[pick*2 +: 2];
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (m.awready[0]) begin
          cnt_d   = awlen_q;
          ptr_d   = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + PW'(1);
          state_d = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_d = StResp;
        end
      end
      StResp: begin
        if (b_hs) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gidx_q    <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
    end
  end

  // Only the granted slot ever sees a ready/valid; everything else stays low.
  always_comb begin
    s.awready  = '0;
    s.wready   = '0;
    s.bvalid   = '0;
    s.bid      = m.bid;
    s.bresp    = m.bresp;
    m.awvalid  = 1'b0;
    m.awid     = awid_q;
    m.awaddr   = awaddr_q;
    m.awlen    = awlen_q;
    m.awsize   = awsize_q;
    m.awburst  = awburst_q;
    m.wid      = s.wid[gidx_q*IW +: IW];
    m.wdata    = s.wdata[gidx_q*DW +: DW];
    m.wstrb    = s.wstrb[gidx_q*SW +: SW];
    m.wlast    = 1'b0;
    m.wvalid   = 1'b0;
    m.bready   = 1'b0;
    unique case (state_q)
      StAddr: begin
        m.awvalid         = 1'b1;
        s.awready[gidx_q] = m.awready[0];
      end
      StData: begin
        m.wvalid         = s.wvalid[gidx_q];
        m.wlast          = (cnt_q == 4'd0);
        s.wready[gidx_q] = m.wready[0];
      end
      StResp: begin
        m.bready         = s.bready[gidx_q];
        s.bvalid[gidx_q] = m.bvalid[0];
      end
      default: ;
    endcase
  end

  assign grant = grant_q;

`ifdef AXI3_ARB_WID_CHECK_EN
  logic wid_err_q;
  logic wid_bad;

  assign wid_bad = (s.wid[gidx_q*IW +: IW] != awid_q) ||
                   (s.wlast[gidx_q] != (cnt_q == 4'd0));

  // Sticky until reset; the offending beat is forwarded regardless.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wid_err_q <= 1'b0;
    end else if (w_hs && wid_bad) begin
      wid_err_q <= 1'b1;
    end
  end

  assign wid_err = wid_err_q;
`else
  logic unused_wlast;
  assign unused_wlast = ^s.wlast;
  assign wid_err      = 1'b0;
`endif

endmodule

// File: tb/tb_axi3_wr_arbiter.sv
// Directed + randomized bench for axi3_wr_arbiter with a transaction-level round-robin model.
module tb_axi3_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;
`ifdef AXI3_ARB_WID_CHECK_EN
  localparam bit WidChk = 1'b1;
`else
  localparam bit WidChk = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [IW-1:0]    id;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [16*DW-1:0] data;
    logic [16*SW-1:0] strb;
    logic [4:0]       bad_beat;
  } txn_t;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [N-1:0] grant;
  logic wid_err;

  always #5 ACLK = ~ACLK;

  axi3_wr_arbiter_if #(.NP(N), .AW(AW), .DW(DW), .IW(IW)) s_if ();
  axi3_wr_arbiter_if #(.NP(1), .AW(AW), .DW(DW), .IW(IW)) m_if ();

  axi3_wr_arbiter #(.N(N), .AW(AW), .DW(DW), .IW(IW)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .s      (s_if),
    .m      (m_if),
    .grant  (grant),
    .wid_err(wid_err)
  );

  int checks;
  int errors;

  // Requester-side queues and per-requester progress.
  txn_t rq[N][$];
  logic [N-1:0] awv, wv, awdone;
  int wbeat[N];

  // Stimulus knobs.
  bit aggr, early_w, br_rand;
  int awr_mode, wr_mode;

  // Manager-side B responder.
  bit mb_pend, mbv;
  logic [IW-1:0] mb_id;
  logic [1:0] mb_resp;

  // Reference model: who owns the port and how far its transaction has progressed.
  int owner, rr_next, beats_m, addr_cyc, cyc;
  bit awdone_m, werr_m;
  txn_t cur;
  int order_q[$];

  // Observations used by directed checks.
  int req_cyc, first_aw_cyc, obs_beats, obs_last;
  logic [DW-1:0] first_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int from);
    for (int k = 0; k < N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic txn_t rand_txn(input int bad);
    txn_t t;
    t.addr  = $urandom;
    t.id    = IW'($urandom);
    t.len   = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
    t.size  = 3'($urandom);
    t.burst = 2'($urandom);
    for (int b = 0; b < 16; b++) begin
      t.data[b*DW +: DW] = $urandom;
      t.strb[b*SW +: SW] = SW'($urandom);
    end
    t.bad_beat = 5'(bad);
    return t;
  endfunction

  task automatic clear_req();
    awv = '0;
    wv = '0;
    awdone = '0;
    for (int i = 0; i < N; i++) wbeat[i] = 0;
  endtask

  task automatic clear_obs();
    req_cyc = -1;
    first_aw_cyc = -1;
    obs_beats = 0;
    obs_last = 0;
    first_wdata = '0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    clear_req();
    s_if.awvalid = '0; s_if.wvalid = '0; s_if.bready = '0;
    s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awburst = '0;
    s_if.wid = '0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = '0;
    m_if.awready = '0; m_if.wready = '0; m_if.bvalid = '0; m_if.bid = '0; m_if.bresp = '0;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_grant", grant, 0);
    check("rst_m_awvalid", m_if.awvalid, 0);
    check("rst_m_wvalid", m_if.wvalid, 0);
    check("rst_m_bready", m_if.bready, 0);
    check("rst_s_awready", s_if.awready, 0);
    check("rst_s_wready", s_if.wready, 0);
    check("rst_wid_err", wid_err, 0);
    ARESET = 1'b0;
    owner = -1; rr_next = 0; werr_m = 1'b0;
    mb_pend = 1'b0; mbv = 1'b0;
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+5, advance model after the edge.
  task automatic step();
    logic [N-1:0] oh;
    bit ph_a, ph_d, ph_r, wv_o, aw_hs, w_hs, b_hs;
    int o, pick;
    txn_t t;
    logic [IW-1:0] exp_wid;

    for (int i = 0; i < N; i++) begin
      if (!awv[i] && !awdone[i] && rq[i].size() > 0 && (aggr || $urandom_range(2) == 0)) begin
        awv[i] = 1'b1;
        if (req_cyc < 0) req_cyc = cyc;
      end
      if (rq[i].size() > 0 && !wv[i] && (awdone[i] || (awv[i] && early_w)) &&
          wbeat[i] <= int'(rq[i][0].len) && (aggr || $urandom_range(1) == 0))
        wv[i] = 1'b1;
      s_if.awvalid[i] = awv[i];
      s_if.wvalid[i]  = wv[i];
      s_if.bready[i]  = br_rand ? 1'($urandom_range(1)) : 1'b1;
      if (rq[i].size() > 0) begin
        t = rq[i][0];
        s_if.awid[i*IW +: IW]  = t.id;
        s_if.awaddr[i*AW +: AW] = t.addr;
        s_if.awlen[i*4 +: 4]   = t.len;
        s_if.awsize[i*3 +: 3]  = t.size;
        s_if.awburst[i*2 +: 2] = t.burst;
        s_if.wid[i*IW +: IW]   = (wbeat[i] == int'(t.bad_beat)) ? t.id + 4'd1 : t.id;
        s_if.wdata[i*DW +: DW] = t.data[(wbeat[i] & 15)*DW +: DW];
        s_if.wstrb[i*SW +: SW] = t.strb[(wbeat[i] & 15)*SW +: SW];
        s_if.wlast[i]          = (wbeat[i] == int'(t.len));
      end else begin
        s_if.awid[i*IW +: IW]   = IW'($urandom);
        s_if.awaddr[i*AW +: AW] = $urandom;
        s_if.wdata[i*DW +: DW]  = $urandom;
      end
    end
    ph_a = (owner >= 0) && !awdone_m;
    m_if.awready = (awr_mode == 0) ? 1'b1 :
                   (awr_mode == 1) ? 1'($urandom_range(1)) : 1'(addr_cyc >= 5);
    m_if.wready  = (wr_mode == 0) ? 1'b1 :
                   (wr_mode == 1) ? 1'($urandom_range(1)) : 1'(cyc[0]);
    if (mb_pend && !mbv && (!br_rand || $urandom_range(1) == 0)) begin
      mbv = 1'b1;
      mb_resp = br_rand ? 2'($urandom) : 2'b00;
    end
    m_if.bvalid = mbv;
    m_if.bid    = mb_id;
    m_if.bresp  = mb_resp;

    #4;
    o    = (owner < 0) ? 0 : owner;
    oh   = (owner >= 0) ? ({{(N-1){1'b0}}, 1'b1} << owner) : '0;
    ph_d = (owner >= 0) && awdone_m && beats_m <= int'(cur.len);
    ph_r = (owner >= 0) && awdone_m && beats_m > int'(cur.len);
    wv_o = (owner >= 0) && wv[o];
    check("grant", grant, oh);
    check("m_awvalid", m_if.awvalid, ph_a);
    check("s_awready", s_if.awready, (ph_a && m_if.awready[0]) ? oh : '0);
    if (ph_a)
      check("m_aw_fields", {m_if.awid, m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst},
            {cur.id, cur.addr, cur.len, cur.size, cur.burst});
    check("m_wvalid", m_if.wvalid, ph_d && wv_o);
    check("s_wready", s_if.wready, (ph_d && m_if.wready[0]) ? oh : '0);
    if (ph_d && wv_o) begin
      exp_wid = (beats_m == int'(cur.bad_beat)) ? cur.id + 4'd1 : cur.id;
      check("m_wdata", m_if.wdata, cur.data[beats_m*DW +: DW]);
      check("m_wstrb", m_if.wstrb, cur.strb[beats_m*SW +: SW]);
      check("m_wid", m_if.wid, exp_wid);
      check("m_wlast", m_if.wlast, beats_m == int'(cur.len));
    end
    check("m_bready", m_if.bready, ph_r && s_if.bready[o]);
    check("s_bvalid", s_if.bvalid, (ph_r && mbv) ? oh : '0);
    if (ph_r && mbv) check("s_bid_bresp", {s_if.bid, s_if.bresp}, {mb_id, mb_resp});
    check("wid_err", wid_err, werr_m);
    if (m_if.wvalid[0] && m_if.wready[0]) begin
      obs_beats++;
      if (obs_beats == 1) first_wdata = m_if.wdata;
      if (m_if.wlast[0]) obs_last++;
    end
    if (m_if.awvalid[0] && first_aw_cyc < 0) first_aw_cyc = cyc;
    aw_hs = ph_a && m_if.awready[0];
    w_hs  = ph_d && wv_o && m_if.wready[0];
    b_hs  = ph_r && mbv && s_if.bready[o];
    pick  = rr_pick(awv, rr_next);

    @(posedge ACLK);
    #1;
    cyc++;
    if (owner < 0) begin
      if (pick >= 0) begin
        owner = pick; cur = rq[pick][0];
        awdone_m = 1'b0; beats_m = 0; addr_cyc = 0;
      end
    end else begin
      if (ph_a) addr_cyc++;
      if (aw_hs) begin
        awdone_m = 1'b1; rr_next = (owner + 1) % N; order_q.push_back(owner);
        awv[owner] = 1'b0; awdone[owner] = 1'b1; mb_id = cur.id;
      end
      if (w_hs) begin
        if (WidChk && beats_m == int'(cur.bad_beat)) werr_m = 1'b1;
        if (beats_m == int'(cur.len)) mb_pend = 1'b1;
        beats_m++; wv[owner] = 1'b0; wbeat[owner]++;
      end
      if (b_hs) begin
        mbv = 1'b0; mb_pend = 1'b0;
        void'(rq[owner].pop_front());
        awdone[owner] = 1'b0; wbeat[owner] = 0; wv[owner] = 1'b0;
        owner = -1;
      end
    end
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
    return owner >= 0;
  endfunction

  task automatic run_done(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check("done_in_budget", n < budget, 1);
  endtask

  initial begin
    txn_t t;
    int exp_ord[5];
    checks = 0; errors = 0; cyc = 0; owner = -1; rr_next = 0;
    aggr = 1'b1; early_w = 1'b0; br_rand = 1'b0; awr_mode = 0; wr_mode = 0;
    mb_id = '0; mb_resp = '0; beats_m = 0; addr_cyc = 0; awdone_m = 1'b0; werr_m = 1'b0;
    cur = '0;
    clear_obs();
    do_reset();

    // Single request from requester 2, everything ready.
    t = rand_txn(31); t.addr = 32'h100; t.len = 4'd3;
    rq[2].push_back(t);
    run_done(200);
    check("t1_latency", first_aw_cyc - req_cyc, 1);
    check("t1_beats", obs_beats, 4);
    check("t1_wlast_once", obs_last, 1);
    step();
    check("t1_grant_idle", grant, 0);

    // Four simultaneous single-beat requests, requester 0 comes back afterwards.
    do_reset();
    order_q.delete();
    for (int i = 0; i < N; i++) begin
      t = rand_txn(31); t.len = 4'd0;
      rq[i].push_back(t);
    end
    t = rand_txn(31); t.len = 4'd0;
    rq[0].push_back(t);
    run_done(400);
    exp_ord = '{0, 1, 2, 3, 0};
    check("t2_order_len", order_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < order_q.size()) check("t2_order", order_q[k], exp_ord[k]);
    end

    // AW stalled five cycles, W ready toggling.
    do_reset();
    clear_obs();
    awr_mode = 2; wr_mode = 2;
    t = rand_txn(31); t.len = 4'd5;
    rq[3].push_back(t);
    run_done(400);
    check("t3_beats", obs_beats, 6);
    check("t3_wlast_once", obs_last, 1);

    // W offered before the AW handshake is held off; first beat intact.
    do_reset();
    clear_obs();
    early_w = 1'b1; wr_mode = 0;
    t = rand_txn(31); t.len = 4'd2;
    rq[0].push_back(t);
    run_done(400);
    check("t4_first_wdata", first_wdata, t.data[DW-1:0]);
    check("t4_beats", obs_beats, 3);

    // Reset asserted in the middle of a four-beat burst.
    do_reset();
    early_w = 1'b0; awr_mode = 0;
    t = rand_txn(31); t.len = 4'd3;
    rq[1].push_back(t);
    for (int n = 0; n < 100 && !(owner == 1 && awdone_m && beats_m == 1); n++) step();
    check("t5_reached_beat2", beats_m, 1);
    #2;
    ARESET = 1'b1;
    #1;
    check("t5_async_grant", grant, 0);
    check("t5_async_m_wvalid", m_if.wvalid, 0);
    check("t5_async_s_wready", s_if.wready, 0);
    check("t5_async_m_awvalid", m_if.awvalid, 0);
    void'(rq[1].pop_front());
    do_reset();
    clear_obs();
    t = rand_txn(31); t.len = 4'd1;
    rq[1].push_back(t);
    run_done(200);
    check("t5_fresh_beats", obs_beats, 2);

    // WID mismatch on beat 1.
    do_reset();
    t = rand_txn(1); t.id = 4'd5; t.len = 4'd3;
    rq[1].push_back(t);
    run_done(200);
    repeat (3) step();
    check("t6_wid_err_sticky", wid_err, WidChk);
    do_reset();

    // Randomized traffic.
    for (int r = 0; r < 6; r++) begin
      aggr = 1'($urandom_range(1));
      early_w = 1'($urandom_range(1));
      br_rand = 1'b1;
      awr_mode = $urandom_range(2);
      wr_mode = $urandom_range(2);
      for (int k = 0; k < 12; k++) begin
        t = rand_txn(($urandom_range(7) == 0) ? $urandom_range(3) : 31);
        rq[$urandom_range(N - 1)].push_back(t);
      end
      run_done(4000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
